// File: rtl/mm2s_eth_packetizer.sv
// Converts the 64-bit MM2S read stream into a byte stream for the Ethernet MAC.
// Each packet is a 6-byte header followed by a fixed-length payload, zero-padded if MM2S ends early.
module mm2s_eth_packetizer #(
    parameter int          WORDS_PER_PKT = 128,
    parameter logic [15:0] HDR_MAGIC     = 16'hA55A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        pkt_done,
    output logic [15:0] seq_num,
    output logic [15:0] short_pkts
);

    localparam logic [12:0] LP_WORDS = 13'(WORDS_PER_PKT);
    localparam logic [15:0] LP_LEN   = 16'(8 * WORDS_PER_PKT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_PAD     = 2'd3;

    logic [1:0]  r_state;
    logic [2:0]  r_idx;
    logic [12:0] r_word_cnt;
    logic [15:0] r_pad_left;
    logic [63:0] r_wbuf;
    logic        r_wbuf_full;
    logic        r_last_seen;
    logic        r_m_tlast;
    logic        r_pkt_done;
    logic [15:0] r_seq_num;
    logic [15:0] r_short_pkts;

    logic        w_m_tvalid;
    logic        w_s_tready;
    logic [7:0]  w_m_tdata;
    logic [7:0]  w_hdr_byte;
    logic        w_m_hs;
    logic        w_s_hs;
    logic [12:0] w_word_cnt_inc;
    logic [15:0] w_pad_len;
    logic        w_unused;

    // s_tkeep is deliberately ignored: every byte of an MM2S word is treated as valid.
    assign w_unused = ^s_tkeep;

    assign w_m_hs         = w_m_tvalid & m_tready;
    assign w_s_hs         = w_s_tready & s_tvalid;
    assign w_word_cnt_inc = r_word_cnt + 13'd1;
    assign w_pad_len      = LP_LEN - {w_word_cnt_inc, 3'b000};

    always_comb begin
        w_hdr_byte = 8'h00;
        case (r_idx)
            3'd0:    w_hdr_byte = HDR_MAGIC[15:8];
            3'd1:    w_hdr_byte = HDR_MAGIC[7:0];
            3'd2:    w_hdr_byte = r_seq_num[15:8];
            3'd3:    w_hdr_byte = r_seq_num[7:0];
            3'd4:    w_hdr_byte = LP_LEN[15:8];
            3'd5:    w_hdr_byte = LP_LEN[7:0];
            default: w_hdr_byte = 8'h00;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_m_tvalid = 1'b0;
        w_s_tready = 1'b0;
        w_m_tdata  = 8'h00;
        case (r_state)
            ST_HDR: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = w_hdr_byte;
            end
            ST_PAYLOAD: begin
                w_m_tvalid = r_wbuf_full;
                w_s_tready = ~r_wbuf_full;
                w_m_tdata  = r_wbuf[{r_idx, 3'b000} +: 8];
            end
            ST_PAD: begin
                w_m_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the word buffer is datapath only, qualified by r_wbuf_full, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_s_hs) begin
            r_wbuf <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= 3'd0;
            r_word_cnt   <= 13'd0;
            r_pad_left   <= 16'd0;
            r_wbuf_full  <= 1'b0;
            r_last_seen  <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_seq_num    <= 16'd0;
            r_short_pkts <= 16'd0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_tvalid) begin
                        r_state <= ST_HDR;
                        r_idx   <= 3'd0;
                    end
                end
                ST_HDR: begin
                    if (w_m_hs) begin
                        if (r_idx == 3'd5) begin
                            r_state     <= ST_PAYLOAD;
                            r_idx       <= 3'd0;
                            r_word_cnt  <= 13'd0;
                            r_wbuf_full <= 1'b0;
                            r_last_seen <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_s_hs) begin
                        r_wbuf_full <= 1'b1;
                        r_last_seen <= s_tlast;
                    end
                    if (w_m_hs) begin
                        r_idx <= r_idx + 3'd1;
                        // m_tlast is registered, so it is raised one byte ahead of the final byte.
                        if (r_idx == 3'd6 && w_word_cnt_inc == LP_WORDS) begin
                            r_m_tlast <= 1'b1;
                        end
                        if (r_idx == 3'd7) begin
                            r_wbuf_full <= 1'b0;
                            r_word_cnt  <= w_word_cnt_inc;
                            r_m_tlast   <= 1'b0;
                            if (w_word_cnt_inc == LP_WORDS) begin
                                r_state    <= ST_IDLE;
                                r_pkt_done <= 1'b1;
                                r_seq_num  <= r_seq_num + 16'd1;
                            end else if (r_last_seen) begin
                                r_state    <= ST_PAD;
                                r_pad_left <= w_pad_len;
                                if (r_short_pkts != 16'hFFFF) begin
                                    r_short_pkts <= r_short_pkts + 16'd1;
                                end
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (w_m_hs) begin
                        r_pad_left <= r_pad_left - 16'd1;
                        if (r_pad_left == 16'd2) begin
                            r_m_tlast <= 1'b1;
                        end
                        if (r_pad_left == 16'd1) begin
                            r_m_tlast  <= 1'b0;
                            r_state    <= ST_IDLE;
                            r_pkt_done <= 1'b1;
                            r_seq_num  <= r_seq_num + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_tready   = w_s_tready;
    assign m_tvalid   = w_m_tvalid;
    assign m_tdata    = w_m_tdata;
    assign m_tlast    = r_m_tlast;
    assign pkt_done   = r_pkt_done;
    assign seq_num    = r_seq_num;
    assign short_pkts = r_short_pkts;

endmodule
